// File: rtl/add_pkg.sv
// Shared definitions for the arbitrated carry-split adder: default widths,
// pipeline latency, controller state encoding and the per-stage op tag.
package add_pkg;

    localparam int ADD_WIDTH  = 15;
    localparam int ADD_WIDTH1 = 7;
    localparam int ADD_WIDTH2 = 8;
    localparam int ADD_LAT    = 3;
    localparam int TAG_IDW    = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    // Round-robin successor of a granted requester, wrapping at nreq-1.
    function automatic logic [TAG_IDW-1:0] rr_next(input logic [TAG_IDW-1:0] id,
                                                   input int                 nreq);
        return (int'(id) == nreq - 1) ? '0 : id + TAG_IDW'(1);
    endfunction

endpackage

// File: rtl/add_split_pipe.sv
// Three-stage adder split into an LSB and an MSB segment; the LSB carry is
// folded into the MSB segment in the last stage. Data registers carry no reset.
module add_split_pipe
    import add_pkg::*;
#(
    parameter int WIDTH  = ADD_WIDTH,
    parameter int WIDTH1 = ADD_WIDTH1,
    parameter int WIDTH2 = ADD_WIDTH2
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH1:0]   lo_q, lo_d;
    logic [WIDTH2-1:0] xh_q, xh_d;
    logic [WIDTH2-1:0] yh_q, yh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;

    always_comb begin
        x_d   = x;
        y_d   = y;
        lo_d  = {1'b0, x_q[WIDTH1-1:0]} + {1'b0, y_q[WIDTH1-1:0]};
        xh_d  = x_q[WIDTH-1:WIDTH1];
        yh_d  = y_q[WIDTH-1:WIDTH1];
        // MSB sum is self-sized inside the concat, so the final carry-out drops off
        sum_d = {xh_q + yh_q + WIDTH2'(lo_q[WIDTH1]), lo_q[WIDTH1-1:0]};
    end

    always_ff @(posedge clk) begin
        x_q   <= x_d;
        y_q   <= y_d;
        lo_q  <= lo_d;
        xh_q  <= xh_d;
        yh_q  <= yh_d;
        sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/add_pipe_arb.sv
// Round-robin arbiter sharing one pipelined adder among NREQ requesters, with
// a tag pipe carrying requester IDs alongside the data and an enable/drain FSM.
//
//   state    | meaning
//   ST_IDLE  | quiescent, nothing in flight, no grants
//   ST_RUN   | granting while en=1
//   ST_DRAIN | en dropped, waiting for issued ops to retire; en=1 resumes
module add_pipe_arb
    import add_pkg::*;
#(
    parameter int WIDTH  = ADD_WIDTH,
    parameter int WIDTH1 = ADD_WIDTH1,
    parameter int WIDTH2 = ADD_WIDTH2,
    parameter int NREQ   = 4,
    parameter int IDW    = TAG_IDW,
    parameter int CNTW   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    output logic [NREQ-1:0]       gnt,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [WIDTH-1:0]      res_sum,
    output logic [1:0]            inflight,
    output logic                  idle,
    output logic [CNTW-1:0]       done_cnt
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    tag_t             tag_q [ADD_LAT];
    tag_t             tag_d [ADD_LAT];
    logic [1:0]       inflight_q, inflight_d;
    logic [CNTW-1:0]  done_q, done_d;

    logic             grant_ok;
    logic             gnt_any;
    logic [IDW-1:0]   gnt_id;
    logic [WIDTH-1:0] add_x, add_y, add_sum;
    logic             last_valid;
    int               idx;

    assign last_valid = tag_q[ADD_LAT-1].valid;

    // Grants are allowed in DRAIN too, so re-raising en resumes in the same cycle
    always_comb begin
        grant_ok = en && (state_q != ST_IDLE);
        gnt_any  = 1'b0;
        gnt_id   = '0;
        gnt      = '0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (grant_ok && !gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
        if (gnt_any) begin
            gnt[gnt_id] = 1'b1;
        end
        ptr_d = gnt_any ? rr_next(gnt_id, NREQ) : ptr_q;
        add_x = req_x[int'(gnt_id)*WIDTH +: WIDTH];
        add_y = req_y[int'(gnt_id)*WIDTH +: WIDTH];
    end

    always_comb begin
        tag_d[0].valid = gnt_any;
        tag_d[0].id    = gnt_id;
        for (int i = 1; i < ADD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        inflight_d = inflight_q;
        if (gnt_any && !last_valid) begin
            inflight_d = inflight_q + 2'd1;
        end else if (!gnt_any && last_valid) begin
            inflight_d = inflight_q - 2'd1;
        end

        done_d = last_valid ? done_q + CNTW'(1) : done_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_d = (inflight_q != 2'd0) ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (inflight_q == 2'd0 && !last_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            inflight_q <= '0;
            done_q     <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            for (int i = 0; i < ADD_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    add_split_pipe #(
        .WIDTH  (WIDTH),
        .WIDTH1 (WIDTH1),
        .WIDTH2 (WIDTH2)
    ) u_add (
        .clk (clk),
        .x   (add_x),
        .y   (add_y),
        .sum (add_sum)
    );

    // Unreset adder data must never leak out between results
    assign res_valid = last_valid;
    assign res_id    = tag_q[ADD_LAT-1].id;
    assign res_sum   = last_valid ? add_sum : '0;
    assign inflight  = inflight_q;
    assign idle      = (state_q == ST_IDLE);
    assign done_cnt  = done_q;

endmodule
